// File: rtl/detector_if.sv
// Sample/result bundle between an upstream source and the multiple-of-DIVISOR checker.
interface detector_if #(
    parameter int unsigned WIDTH = 6
);
    logic [WIDTH-1:0] din;
    logic             en;
    logic             dout;
    logic             out_en;

    modport master (
        output din,
        output en,
        input  dout,
        input  out_en
    );

    modport slave (
        input  din,
        input  en,
        output dout,
        output out_en
    );
endinterface

// File: rtl/detector.sv
// Registered flag: is the sampled unsigned din an exact multiple of DIVISOR.
// The residue comes from a weighted bit fold followed by a conditional-subtract chain.
module detector #(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned DIVISOR = 5
) (
    input  logic        clk,
    input  logic        rstn,
    detector_if.slave   bus
);
    // Fold sum < WIDTH*DIVISOR <= 16*DIVISOR, so subtracting 8D,4D,2D,D leaves a value < D.
    localparam int unsigned SumW      = 24;
    localparam int unsigned RedStages = 4;

    function automatic int unsigned pow2_mod(input int unsigned idx);
        int unsigned acc;
        acc = 1 % DIVISOR;
        for (int unsigned j = 0; j < idx; j++) begin
            acc = (acc * 2) % DIVISOR;
        end
        return acc;
    endfunction

    logic [SumW-1:0] w_term [WIDTH];
    logic [SumW-1:0] w_sum;
    logic [SumW-1:0] w_red;
    logic            w_hit;
    logic            r_dout;
    logic            r_out_en;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_weight
        localparam int unsigned Weight = pow2_mod(gi);
        assign w_term[gi] = bus.din[gi] ? SumW'(Weight) : '0;
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum = w_sum + w_term[i];
        end
        w_red = w_sum;
        for (int k = RedStages - 1; k >= 0; k--) begin
            if (w_red >= (SumW'(DIVISOR) << k)) begin
                w_red = w_red - (SumW'(DIVISOR) << k);
            end
        end
        w_hit = (w_red == '0);
    end

    // Gate with en via a mux so an unknown din cannot leak out while disabled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_dout   <= 1'b0;
            r_out_en <= 1'b0;
        end else begin
            r_dout   <= bus.en ? w_hit : 1'b0;
            r_out_en <= bus.en;
        end
    end

    assign bus.dout   = r_dout;
    assign bus.out_en = r_out_en;
endmodule

// File: tb/tb_detector.sv
// Self-checking bench: vector table, directed sequences and random stimulus against a modulo model.
module tb_detector;
    logic clk;
    logic rstn;
    int   n_pass;
    int   n_total;

    detector_if #(.WIDTH(6)) if6 ();
    detector_if #(.WIDTH(8)) if8 ();

    detector #(.WIDTH(6), .DIVISOR(5)) dut6 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if6)
    );

    detector #(.WIDTH(8), .DIVISOR(3)) dut8 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic       en;
        logic [5:0] din;
        logic       exp_dout;
        logic       exp_out_en;
    } vec_t;

    vec_t vecs [12];

    function automatic logic ref_mult(input int v, input int d);
        return (v % d) == 0;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive at the falling edge, let the rising edge sample, look at outputs 1 time unit later.
    task automatic cycle(input logic r, input logic e6, input logic [5:0] d6,
                         input logic e8, input logic [7:0] d8);
        @(negedge clk);
        rstn    = r;
        if6.en  = e6;
        if6.din = d6;
        if8.en  = e8;
        if8.din = d8;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model6(input string tag, input logic r, input logic e, input int d);
        logic exp_en;
        exp_en = r & e;
        check($sformatf("%s out_en6 din=%0d", tag, d), if6.out_en, exp_en);
        check($sformatf("%s dout6 din=%0d", tag, d), if6.dout, exp_en & ref_mult(d, 5));
    endtask

    task automatic check_model8(input string tag, input logic r, input logic e, input int d);
        logic exp_en;
        exp_en = r & e;
        check($sformatf("%s out_en8 din=%0d", tag, d), if8.out_en, exp_en);
        check($sformatf("%s dout8 din=%0d", tag, d), if8.dout, exp_en & ref_mult(d, 3));
    endtask

    initial begin
        int  hits;
        logic e;
        logic r;
        int  d6;
        int  d8;
        logic e8;

        n_pass  = 0;
        n_total = 0;
        rstn    = 1'b0;
        if6.en  = 1'b0;
        if6.din = '0;
        if8.en  = 1'b0;
        if8.din = '0;

        // Reset hold, release, boundaries and a disabled zero.
        vecs[0]  = '{1'b0, 1'b1, 6'd5,  1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 6'd5,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 6'd5,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 6'd5,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 6'd5,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 6'd5,  1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 6'd63, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 6'd62, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 6'd60, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 6'd1,  1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 6'd0,  1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 6'd0,  1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].rstn, vecs[i].en, vecs[i].din, 1'b0, 8'd0);
            check($sformatf("vec%0d dout", i), if6.dout, vecs[i].exp_dout);
            check($sformatf("vec%0d out_en", i), if6.out_en, vecs[i].exp_out_en);
        end

        // Enabled sweep 0..63.
        hits = 0;
        for (int v = 0; v < 64; v++) begin
            cycle(1'b1, 1'b1, 6'(v), 1'b0, 8'd0);
            check_model6("sweep_en", 1'b1, 1'b1, v);
            if (if6.dout === 1'b1) hits++;
        end
        n_total++;
        if (hits != 13) $display("FAIL sweep_hits: got %0d expected 13", hits);
        else n_pass++;

        // Disabled sweep.
        for (int v = 0; v < 64; v++) begin
            cycle(1'b1, 1'b0, 6'(v), 1'b0, 8'd0);
            check($sformatf("sweep_dis dout din=%0d", v), if6.dout, 1'b0);
            check($sformatf("sweep_dis out_en din=%0d", v), if6.out_en, 1'b0);
        end

        // en toggling with din=10.
        for (int i = 0; i < 8; i++) begin
            e = 1'(i % 2 == 0);
            cycle(1'b1, e, 6'd10, 1'b0, 8'd0);
            check($sformatf("toggle%0d out_en", i), if6.out_en, e);
            check($sformatf("toggle%0d dout", i), if6.dout, e);
            check($sformatf("toggle%0d dout_without_out_en", i),
                  if6.dout & ~if6.out_en, 1'b0);
        end

        // Mid-stream reset pulse.
        cycle(1'b1, 1'b1, 6'd30, 1'b0, 8'd0);
        check("mid pre dout", if6.dout, 1'b1);
        cycle(1'b1, 1'b1, 6'd35, 1'b0, 8'd0);
        check("mid 35 dout", if6.dout, 1'b1);
        cycle(1'b0, 1'b1, 6'd35, 1'b0, 8'd0);
        check("mid rst dout", if6.dout, 1'b0);
        check("mid rst out_en", if6.out_en, 1'b0);
        cycle(1'b1, 1'b1, 6'd40, 1'b0, 8'd0);
        check("mid 40 dout", if6.dout, 1'b1);
        check("mid 40 out_en", if6.out_en, 1'b1);

        // Unknown din while disabled.
        @(negedge clk);
        if6.en  = 1'b0;
        if6.din = 'x;
        @(posedge clk);
        #1;
        check("x_din dout", if6.dout, 1'b0);
        check("x_din out_en", if6.out_en, 1'b0);

        // Full sweep of the 8-bit / divide-by-3 instance.
        for (int v = 0; v < 256; v++) begin
            cycle(1'b1, 1'b0, 6'd0, 1'b1, 8'(v));
            check_model8("sweep8", 1'b1, 1'b1, v);
        end

        // Random stimulus on both instances, occasional reset.
        for (int i = 0; i < 300; i++) begin
            r  = 1'($urandom_range(0, 15) != 0);
            e  = 1'($urandom_range(0, 3) != 0);
            e8 = 1'($urandom_range(0, 3) != 0);
            d6 = int'($urandom_range(0, 63));
            d8 = int'($urandom_range(0, 255));
            cycle(r, e, 6'(d6), e8, 8'(d8));
            check_model6("rand", r, e, d6);
            check_model8("rand", r, e8, d8);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
